spart_tx: RTL and testbench

- Transmit half of the SPART. Accepts a byte from the processor-side bus and serialises it onto txd as 8N1 async frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Double-buffered: a one-byte holding register feeds a shift register, so the driver can write the next byte while the current frame is still shifting.
- Bit timing comes from the shared SPART baud generator's oversampled enable tick. Sits beside the SPART receiver inside spart.

---
 rtl/spart_pkg.sv | 7 +
 rtl/spart_tx_bittimer.sv | 20 ++
 rtl/spart_tx.sv | 103 ++++++++++
 tb/tb_spart_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART types and constants for the transmitter and receiver.
package spart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_e;
  localparam int DATA_BITS_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam logic [1:0] IOADDR_TXRX = 2'b00;
endpackage

// File: rtl/spart_tx_bittimer.sv
// spart_tx_bittimer: counts baud enables and flags the last enable of each bit period.
module spart_tx_bittimer
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic run,
  input  logic clear,
  output logic bit_done
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign bit_done = enable & run & (cnt_q == LAST);
  always_comb cnt_d = (clear | bit_done) ? '0 : (enable & run) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/spart_tx.sv
// spart_tx: double-buffered 8N1 serial transmitter driven by an oversampled baud enable.
// Define SPART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module spart_tx
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 tx_load,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  output logic                 tbr,
  output logic                 tx_busy
);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  tx_state_e state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic hold_full_q, hold_full_d, txd_q, txd_d, bit_done, xfer, accept;
`ifdef SPART_TX_PARITY_EN
  logic par_q, par_d;
  localparam tx_state_e AFTER_DATA = PARITY;
`else
  localparam tx_state_e AFTER_DATA = STOP;
`endif
  spart_tx_bittimer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .run     (state_q != IDLE),
    .clear   (state_q == IDLE),
    .bit_done(bit_done)
  );
  // A stop bit ending with a full holding register chains straight into the next start bit.
  always_comb begin
    xfer = hold_full_q & ((state_q == IDLE) | ((state_q == STOP) & bit_done));
    accept = tx_load & ~hold_full_q;
    hold_d = accept ? tx_data : hold_q;
    hold_full_d = xfer ? 1'b0 : accept ? 1'b1 : hold_full_q;
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    if (xfer) begin
      state_d = START;
      shift_d = hold_q;
      idx_d = '0;
    end else if (bit_done) begin
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d = '0;
        end
        DATA: begin
          shift_d = shift_q >> 1;
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          state_d = (idx_q == LAST_IDX) ? AFTER_DATA : DATA;
        end
`ifdef SPART_TX_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
`ifdef SPART_TX_PARITY_EN
    par_d = xfer ? ^hold_q : par_q;
    txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
            (state_d == PARITY) ? par_d : 1'b1;
`else
    txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      shift_q <= '0;
      idx_q <= '0;
      txd_q <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      txd_q <= txd_d;
`ifdef SPART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign txd = txd_q;
  assign tbr = ~hold_full_q;
  assign tx_busy = (state_q != IDLE);
endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: scoreboard bench for spart_tx; a serial monitor decodes txd and pops expected bytes.
module tb_spart_tx;
  localparam int OS = 16;
`ifdef SPART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  logic clk = 1'b0, rst = 1'b0, tx_load = 1'b0, sparse = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] div = 2'd0;
  logic enable, txd, tbr, tx_busy;
  int checks = 0, errors = 0, bit_clk = OS;
  logic [7:0] sb[$];
  logic mon_act = 1'b0;
  int mon_cnt = 0, mon_k = 0;
  logic [10:0] mon_bits, exp_bits;
  logic [7:0] exp_d;

  assign enable = sparse ? (div == 2'd0) : 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;

  spart_tx dut (
    .clk(clk), .rst(rst), .enable(enable), .tx_load(tx_load),
    .tx_data(tx_data), .txd(txd), .tbr(tbr), .tx_busy(tx_busy)
  );

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef SPART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Mid-bit sampling of each frame; a reset abandons the frame being decoded.
  always @(negedge clk) begin
    if (!rst) mon_act = 1'b0;
    else if (!mon_act) begin
      if (txd === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        mon_bits = '0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % bit_clk == bit_clk / 2) begin
        mon_k = mon_cnt / bit_clk;
        mon_bits[mon_k] = txd;
        if (mon_k == FRAME - 1) begin
          mon_act = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_extra unexpected frame bits=%b", mon_bits);
          end else begin
            exp_d = sb.pop_front();
            exp_bits = '0;
            for (int i = 0; i < FRAME; i++) exp_bits[i] = exp_bit(exp_d, i);
            if (mon_bits !== exp_bits) begin
              errors++;
              $display("FAIL sb_frame got=%b exp=%b (byte %h)", mon_bits, exp_bits, exp_d);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] d, input bit acc);
    tx_data = d;
    tx_load = 1'b1;
    if (acc) sb.push_back(d);
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy !== 1'b0 || tbr !== 1'b1) && n < 5000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%b tbr=%b", tx_busy, tbr);
    end
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    checks += 3;
    if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got=%b exp=1", txd); end
    if (tbr !== 1'b1) begin errors++; $display("FAIL rst_tbr got=%b exp=1", tbr); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", tx_busy); end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_frame(input logic [7:0] d);
    load(d, 1'b1);
    checks += 2;
    if (tbr !== 1'b0) begin errors++; $display("FAIL frame_tbr_n1 got=%b exp=0", tbr); end
    if (txd !== 1'b1) begin errors++; $display("FAIL frame_txd_n1 got=%b exp=1", txd); end
    tick(1);
    checks++;
    if (tbr !== 1'b1) begin errors++; $display("FAIL frame_tbr_n2 got=%b exp=1", tbr); end
    for (int c = 0; c < FRAME * OS; c++) begin
      checks++;
      if (txd !== exp_bit(d, c / OS) || tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL frame_wave byte=%h cyc=%0d txd=%b busy=%b exp txd=%b busy=1",
                 d, c, txd, tx_busy, exp_bit(d, c / OS));
      end
      tick(1);
    end
    checks++;
    if (tx_busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL frame_end busy=%b txd=%b exp busy=0 txd=1", tx_busy, txd);
    end
    tick(2);
  endtask

  task automatic test_sparse();
    int n = 0;
    sparse = 1'b1;
    bit_clk = 4 * OS;
    tick(1);
    while (div != 2'd3) tick(1);
    load(8'h00, 1'b1);
    tick(1);
    while (txd === 1'b0 && n < 2000) begin
      n++;
      tick(1);
    end
    checks++;
    if (n != 9 * 4 * OS) begin errors++; $display("FAIL sparse_low got=%0d exp=%0d", n, 9 * 4 * OS); end
    wait_idle();
    sparse = 1'b0;
    bit_clk = OS;
  endtask

  task automatic test_back_to_back();
    bit dropped = 1'b0;
    load(8'h55, 1'b1);
    tick(9);
    load(8'h0F, 1'b1);
    checks++;
    if (tbr !== 1'b0) begin errors++; $display("FAIL b2b_tbr got=%b exp=0", tbr); end
    for (int i = 0; i < 150; i++) begin
      if (tx_busy !== 1'b1) dropped = 1'b1;
      tick(1);
    end
    checks += 3;
    if (txd !== 1'b1) begin errors++; $display("FAIL b2b_stop got=%b exp=1", txd); end
    tick(1);
    if (txd !== 1'b0) begin errors++; $display("FAIL b2b_start got=%b exp=0", txd); end
    if (dropped || tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_gap busy dropped=%b exp=0", dropped); end
    wait_idle();
  endtask

  task automatic test_overrun();
    load(8'h11, 1'b1);
    tick(1);
    load(8'h22, 1'b1);
    checks++;
    if (tbr !== 1'b0) begin errors++; $display("FAIL ovr_tbr got=%b exp=0", tbr); end
    load(8'h33, 1'b0);
    wait_idle();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL ovr_sb pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    load(8'h3C, 1'b1);
    tick(68);
    rst = 1'b0;
    tick(1);
    checks += 3;
    if (txd !== 1'b1) begin errors++; $display("FAIL rmid_txd got=%b exp=1", txd); end
    if (tbr !== 1'b1) begin errors++; $display("FAIL rmid_tbr got=%b exp=1", tbr); end
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", tx_busy); end
    rst = 1'b1;
    sb.delete();
    tick(2);
    load(8'h81, 1'b1);
    wait_idle();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rmid_sb pending=%0d exp=0", sb.size()); end
  endtask

`ifdef SPART_TX_PARITY_EN
  task automatic test_parity();
    test_frame(8'h07);
    test_frame(8'h03);
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_sparse();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef SPART_TX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_sb pending=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
